// File: rtl/lsu_mem_initiator.sv
// Memory-stage load/store initiator: validates one pipeline access, issues a single
// word-addressed request over req/ready, and returns extended load data.
module lsu_mem_initiator #(
  parameter logic [31:0] DM_BASE  = 32'h0000_0000,
  parameter logic [31:0] DM_BYTES = 32'd16384
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        exc,
  output logic [31:0] rdata,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [3:0]  m_be,
  output logic [31:0] m_wdata,
  input  logic        m_ready,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  state_t      state_reg, state_next;
  logic [2:0]  op_reg;
  logic [1:0]  lane_reg;
  logic        fault_reg;
  logic        we_reg;
  logic [31:0] addr_reg;
  logic [3:0]  be_reg;
  logic [31:0] wdata_reg;
  logic [31:0] rdata_reg;

  logic        is_word, is_half, fault;
  logic [31:0] offset;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [31:0] shifted;
  logic [31:0] load_ext;

  // Offset wraps as unsigned, so addresses below DM_BASE are caught by the same compare.
  always_comb begin
    is_word = (op == OP_LW) || (op == OP_SW);
    is_half = (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
    offset  = addr - DM_BASE;
    fault   = (is_word && (addr[1:0] != 2'b00)) ||
              (is_half && addr[0]) ||
              (offset >= DM_BYTES);
  end

  always_comb begin
    be_next    = 4'b1111;
    wdata_next = wdata;
    case (op)
      OP_SH: begin
        be_next    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{wdata[15:0]}};
      end
      OP_SB: begin
        be_next    = 4'b0001 << addr[1:0];
        wdata_next = {4{wdata[7:0]}};
      end
      default: begin
        be_next    = 4'b1111;
        wdata_next = wdata;
      end
    endcase
  end

  always_comb begin
    shifted  = m_rdata >> {lane_reg, 3'b000};
    load_ext = m_rdata;
    case (op_reg)
      OP_LH:   load_ext = {{16{shifted[15]}}, shifted[15:0]};
      OP_LHU:  load_ext = {16'h0000, shifted[15:0]};
      OP_LB:   load_ext = {{24{shifted[7]}}, shifted[7:0]};
      OP_LBU:  load_ext = {24'h000000, shifted[7:0]};
      default: load_ext = m_rdata;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (op_valid) state_next = fault ? DONE : REQ;
      REQ:  if (m_ready) state_next = we_reg ? DONE : RESP;
      RESP: if (m_rvalid) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      op_reg    <= 3'd0;
      lane_reg  <= 2'd0;
      fault_reg <= 1'b0;
      we_reg    <= 1'b0;
      addr_reg  <= 32'd0;
      be_reg    <= 4'd0;
      wdata_reg <= 32'd0;
      rdata_reg <= 32'd0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && op_valid) begin
        op_reg    <= op;
        lane_reg  <= addr[1:0];
        fault_reg <= fault;
        we_reg    <= (op >= OP_SW);
        addr_reg  <= {addr[31:2], 2'b00};
        be_reg    <= be_next;
        wdata_reg <= wdata_next;
      end
      if (state_reg == RESP && m_rvalid) rdata_reg <= load_ext;
    end
  end

  assign busy    = (state_reg != IDLE);
  assign done    = (state_reg == DONE);
  assign exc     = (state_reg == DONE) && fault_reg;
  assign m_req   = (state_reg == REQ);
  assign m_we    = we_reg;
  assign m_addr  = addr_reg;
  assign m_be    = be_reg;
  assign m_wdata = wdata_reg;
  assign rdata   = rdata_reg;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Bench for lsu_mem_initiator: directed vector table, randomized accesses checked
// against a byte-level reference model, and reset / stray-response sequences.
module tb_lsu_mem_initiator;

  localparam logic [31:0] DM_BASE  = 32'h0000_0000;
  localparam logic [31:0] DM_BYTES = 32'd16384;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] addr, wdata;
  logic        busy, done, exc;
  logic [31:0] rdata;
  logic        m_req, m_we;
  logic [31:0] m_addr;
  logic [3:0]  m_be;
  logic [31:0] m_wdata;
  logic        m_ready, m_rvalid;
  logic [31:0] m_rdata;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] last_rdata;

  lsu_mem_initiator #(.DM_BASE(DM_BASE), .DM_BYTES(DM_BYTES)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .exc(exc), .rdata(rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_be(m_be), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] word;
    logic        exc;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] rd;
  } vec_t;

  typedef struct {
    logic        exc;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] rd;
  } ref_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Byte-lane view of the access: size, lane window, replication and extension.
  function automatic ref_t ref_model(input logic [2:0] o, input logic [31:0] a,
                                     input logic [31:0] w, input logic [31:0] word);
    ref_t r;
    int size, lane;
    bit load, sgn;
    logic [31:0] off;
    load = (o < 3'd5);
    size = (o == 3'd0 || o == 3'd5) ? 4 : (o == 3'd1 || o == 3'd2 || o == 3'd6) ? 2 : 1;
    sgn  = (o == 3'd1 || o == 3'd3);
    off  = a - DM_BASE;
    lane = int'(a[1:0]);
    r.exc = ((a % 32'(size)) != 0) || (off >= DM_BYTES);
    r.be = 4'd0;
    r.wd = 32'd0;
    r.rd = 32'd0;
    for (int i = 0; i < 4; i++) begin
      if (load || (i >= lane && i < lane + size)) r.be[i] = 1'b1;
      r.wd[8*i +: 8] = w[8*(i % size) +: 8];
    end
    for (int i = 0; i < size; i++) r.rd[8*i +: 8] = word[8*(lane+i) +: 8];
    if (sgn && r.rd[8*size-1])
      for (int i = size; i < 4; i++) r.rd[8*i +: 8] = 8'hFF;
    return r;
  endfunction

  // Entered and left one time unit after a posedge with the DUT idle.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] w,
                        input logic [31:0] word, input int stall, input int rlat,
                        input logic e_exc, input logic [3:0] e_be,
                        input logic [31:0] e_wd, input logic [31:0] e_rd);
    int exp_lat, reqc, k;
    bit hs, finished, store;
    store = (o >= 3'd5);
    exp_lat = e_exc ? 1 : (store ? 2 + stall : 2 + stall + rlat);
    op_valid = 1'b1; op = o; addr = a; wdata = w; m_rdata = word;
    @(posedge clk); #1;
    op_valid = 1'b0;
    reqc = 0; k = 0; hs = 0; finished = 0;
    for (int c = 1; c <= 40 && !finished; c++) begin
      if (hs) k++;
      m_rvalid = hs && (k == rlat);
      if (done) begin
        if (!store && !e_exc) last_rdata = e_rd;
        chk("latency", 32'(c), 32'(exp_lat));
        chk("exc", 32'(exc), 32'(e_exc));
        chk("rdata", rdata, last_rdata);
        chk("busy_at_done", 32'(busy), 32'd1);
        chk("req_cycles", 32'(reqc), e_exc ? 32'd0 : 32'(stall + 1));
        finished = 1;
        m_rvalid = 1'b0;
      end else begin
        if (m_req) begin
          chk("m_we", 32'(m_we), 32'(store));
          chk("m_addr", m_addr, {a[31:2], 2'b00});
          chk("m_be", 32'(m_be), 32'(e_be));
          if (store) chk("m_wdata", m_wdata, e_wd);
          m_ready = (reqc >= stall);
          if (m_ready) hs = 1;
          reqc++;
        end else begin
          m_ready = 1'b0;
        end
        @(posedge clk); #1;
      end
    end
    chk("done_seen", 32'(finished), 32'd1);
    m_ready = 1'b0; m_rvalid = 1'b0;
    @(posedge clk); #1;
    chk("done_pulse_end", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("exc_outside_done", 32'(exc), 32'd0);
    $display("op=%0d addr=%h wdata=%h word=%h stall=%0d rlat=%0d exc=%0b rdata=%h",
             o, a, w, word, stall, rlat, e_exc, rdata);
  endtask

  vec_t tbl[14];
  ref_t r;

  initial begin
    reset = 1'b1; op_valid = 1'b0; op = 3'd0; addr = 32'd0; wdata = 32'd0;
    m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = 32'd0;
    last_rdata = 32'd0;

    tbl[0]  = '{3'd5, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0, 4'b1111, 32'hDEADBEEF, 32'h0};
    tbl[1]  = '{3'd7, 32'h23,   32'h000000A5, 32'h0,        1'b0, 4'b1000, 32'hA5A5A5A5, 32'h0};
    tbl[2]  = '{3'd6, 32'h22,   32'h00001234, 32'h0,        1'b0, 4'b1100, 32'h12341234, 32'h0};
    tbl[3]  = '{3'd3, 32'h43,   32'h0,        32'h80F07F01, 1'b0, 4'b1111, 32'h0, 32'hFFFFFF80};
    tbl[4]  = '{3'd4, 32'h43,   32'h0,        32'h80F07F01, 1'b0, 4'b1111, 32'h0, 32'h00000080};
    tbl[5]  = '{3'd3, 32'h40,   32'h0,        32'h80F07F01, 1'b0, 4'b1111, 32'h0, 32'h00000001};
    tbl[6]  = '{3'd1, 32'h42,   32'h0,        32'h80F07F01, 1'b0, 4'b1111, 32'h0, 32'hFFFF80F0};
    tbl[7]  = '{3'd2, 32'h42,   32'h0,        32'h80F07F01, 1'b0, 4'b1111, 32'h0, 32'h000080F0};
    tbl[8]  = '{3'd0, 32'h40,   32'h0,        32'h80F07F01, 1'b0, 4'b1111, 32'h0, 32'h80F07F01};
    tbl[9]  = '{3'd0, 32'h02,   32'h0,        32'h0,        1'b1, 4'b1111, 32'h0, 32'h0};
    tbl[10] = '{3'd6, 32'h01,   32'h0,        32'h0,        1'b1, 4'b0011, 32'h0, 32'h0};
    tbl[11] = '{3'd0, 32'h4000, 32'h0,        32'h0,        1'b1, 4'b1111, 32'h0, 32'h0};
    tbl[12] = '{3'd7, 32'h3FFF, 32'h0000005A, 32'h0,        1'b0, 4'b1000, 32'h5A5A5A5A, 32'h0};
    tbl[13] = '{3'd1, 32'h3FFE, 32'h0,        32'h7F001234, 1'b0, 4'b1111, 32'h0, 32'h00007F00};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_exc", 32'(exc), 32'd0);
    chk("rst_m_req", 32'(m_req), 32'd0);
    chk("rst_m_we", 32'(m_we), 32'd0);
    chk("rst_m_addr", m_addr, 32'd0);
    chk("rst_m_be", 32'(m_be), 32'd0);
    chk("rst_m_wdata", m_wdata, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++)
      run_op(tbl[i].op, tbl[i].addr, tbl[i].wdata, tbl[i].word, 0, 1,
             tbl[i].exc, tbl[i].be, tbl[i].wd, tbl[i].rd);

    // Stalled handshake then a slow response; done lands 7 cycles after accept.
    r = ref_model(3'd0, 32'h40, 32'h0, 32'hCAFEF00D);
    run_op(3'd0, 32'h40, 32'h0, 32'hCAFEF00D, 3, 2, r.exc, r.be, r.wd, r.rd);
    m_rvalid = 1'b1; m_rdata = 32'h11111111;
    repeat (2) @(posedge clk);
    #1;
    m_rvalid = 1'b0;
    chk("stray_rvalid_rdata", rdata, 32'hCAFEF00D);
    chk("stray_rvalid_busy", 32'(busy), 32'd0);

    // Reset while waiting for the read response.
    op_valid = 1'b1; op = 3'd0; addr = 32'h40;
    @(posedge clk); #1;
    op_valid = 1'b0; m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    chk("resp_busy", 32'(busy), 32'd1);
    chk("resp_m_req", 32'(m_req), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; last_rdata = 32'd0;
    m_rvalid = 1'b1; m_rdata = 32'h12345678;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_m_req", 32'(m_req), 32'd0);
    @(posedge clk); #1;
    m_rvalid = 1'b0;
    chk("midrst_done2", 32'(done), 32'd0);
    chk("midrst_busy2", 32'(busy), 32'd0);
    chk("midrst_rdata", rdata, 32'd0);
    run_op(3'd5, 32'h80, 32'h01020304, 32'h0, 0, 1, 1'b0, 4'b1111, 32'h01020304, 32'h0);

    for (int n = 0; n < 60; n++) begin
      logic [2:0]  ro;
      logic [31:0] ra, rw, rwd;
      int st, rl;
      ro  = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) < 8) begin
        ra = DM_BASE + 32'($urandom_range(0, 16383));
        if ($urandom_range(0, 3) != 0) ra[1:0] = (ro == 3'd0 || ro == 3'd5) ? 2'b00 :
                                                   (ro == 3'd3 || ro == 3'd4 || ro == 3'd7) ? ra[1:0] :
                                                   {ra[1], 1'b0};
      end else begin
        ra = $urandom;
      end
      rw  = $urandom;
      rwd = $urandom;
      st  = $urandom_range(0, 2);
      rl  = $urandom_range(1, 3);
      r = ref_model(ro, ra, rw, rwd);
      run_op(ro, ra, rw, rwd, st, rl, r.exc, r.be, r.wd, r.rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
